proj_frag_fetcher: RTL and testbench

- Memory-side responder for the fragment request interface driven by proj_extender.
- Accepts a signed bit-index request relative to a base bit pointer.
- Reads one or two words from a synchronous single-port RAM and returns the FRAG_LEN-bit window starting at that bit.
- Bits outside the memory's bit range are returned as 0. This replaces the ad-hoc combinational padding model with a cycle-accurate, handshaked fetcher.

---
 rtl/proj_frag_fetcher.sv | 85 ++++++++
 tb/tb_proj_frag_fetcher.sv | 138 +++++++++++++
 2 files changed

// File: rtl/proj_frag_fetcher.sv
// proj_frag_fetcher: handshaked fetch of a FRAG_LEN-bit window at a signed bit offset from synchronous RAM, zero-filling out-of-range bits
module proj_frag_fetcher #(
  parameter int FRAG_LEN = 8,
  parameter int INDICE_LEN = 5,
  parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1,
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 32,
  parameter int ADDR_W = $clog2(MEM_DEPTH),
  parameter int BIT_ADDR_W = $clog2(MEM_WIDTH * MEM_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [BIT_ADDR_W-1:0]        req_base,
  input  logic [SIGNED_INDICE_LEN-1:0] req_index,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [FRAG_LEN-1:0]          rsp_fragment,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [MEM_WIDTH-1:0]         mem_rdata
);
  localparam int EA_W = BIT_ADDR_W + 2;
  localparam int OFF_W = $clog2(MEM_WIDTH);
  localparam logic signed [EA_W-1:0] TOT = EA_W'(MEM_WIDTH * MEM_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_RSP} state_t;
  state_t state, state_n;
  logic signed [EA_W-1:0] ea_n, last_n, ea_r;
  logic [ADDR_W-1:0] w_lo_n, w_hi_n, w_lo_r, w_hi_r;
  logic out_n, two_r;
  logic [MEM_WIDTH-1:0] lo_word, lo_src;
  logic [FRAG_LEN-1:0] frag, frag_n;
  assign ea_n = $signed({2'b00, req_base}) + $signed({{(EA_W-SIGNED_INDICE_LEN){req_index[SIGNED_INDICE_LEN-1]}}, req_index});
  assign last_n = ea_n + EA_W'(FRAG_LEN - 1);
  assign out_n = last_n[EA_W-1] || ea_n >= TOT;
  assign w_lo_n = ea_n[EA_W-1] ? '0 : ea_n[BIT_ADDR_W-1:OFF_W];
  assign w_hi_n = last_n >= TOT ? ADDR_W'(MEM_DEPTH - 1) : last_n[BIT_ADDR_W-1:OFF_W];
  // for a single-word fetch the only word read is arriving now in S_CAP
  assign lo_src = two_r ? lo_word : mem_rdata;
  for (genvar i = 0; i < FRAG_LEN; i++) begin : g_bit
    logic signed [EA_W-1:0] b;
    assign b = ea_r + EA_W'(i);
    assign frag_n[i] = (b[EA_W-1] || b >= TOT) ? 1'b0 :
                       b[BIT_ADDR_W-1:OFF_W] == w_lo_r ? lo_src[b[OFF_W-1:0]] : mem_rdata[b[OFF_W-1:0]];
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = req_valid ? (out_n ? S_RSP : S_RD_LO) : S_IDLE;
      S_RD_LO: state_n = two_r ? S_RD_HI : S_CAP;
      S_RD_HI: state_n = S_CAP;
      S_CAP:   state_n = S_RSP;
      S_RSP:   state_n = rsp_ready ? S_IDLE : S_RSP;
      default: state_n = S_IDLE;
    endcase
  end
  assign req_ready = state == S_IDLE;
  assign rsp_valid = state == S_RSP;
  assign rsp_fragment = frag;
  assign mem_rd_en = state == S_RD_LO || state == S_RD_HI;
  assign mem_addr = state == S_RD_LO ? w_lo_r : state == S_RD_HI ? w_hi_r : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ea_r <= '0;
      w_lo_r <= '0;
      w_hi_r <= '0;
      two_r <= 1'b0;
      lo_word <= '0;
      frag <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && req_valid) begin
        ea_r <= ea_n;
        w_lo_r <= w_lo_n;
        w_hi_r <= w_hi_n;
        two_r <= w_hi_n != w_lo_n;
        frag <= '0;
      end
      if (state == S_RD_HI) lo_word <= mem_rdata;
      if (state == S_CAP) frag <= frag_n;
    end
  end
endmodule

// File: tb/tb_proj_frag_fetcher.sv
// tb_proj_frag_fetcher: directed scoreboard bench with a behavioural synchronous RAM
module tb_proj_frag_fetcher;
  logic clk, rst, req_valid, req_ready, rsp_valid, rsp_ready, mem_rd_en;
  logic [9:0] req_base;
  logic [5:0] req_index;
  logic [7:0] rsp_fragment;
  logic [4:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem [32];
  logic [7:0] exp_q [$];
  int rd_q [$];
  int errors = 0, checks = 0;

  proj_frag_fetcher dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_index(req_index), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_fragment(rsp_fragment), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
  always @(negedge clk) if (mem_rd_en) rd_q.push_back(int'(mem_addr));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", int'(rsp_fragment), -1);
      else chk("fragment", int'(rsp_fragment), int'(exp_q.pop_front()));
    end
  end

  task automatic send(input int base, input int idx, input logic [7:0] f,
                      input int lat_e, input int nrd, input int a0, input int a1);
    int lat;
    exp_q.push_back(f);
    @(posedge clk); #1;
    rd_q.delete();
    req_valid = 1'b1;
    req_base = base[9:0];
    req_index = idx[5:0];
    @(negedge clk);
    chk("req_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_base = 10'h3FF;
    req_index = 6'h1F;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, lat_e);
    chk("reads", rd_q.size(), nrd);
    if (nrd > 0 && rd_q.size() > 0) chk("addr0", rd_q[0], a0);
    if (nrd > 1 && rd_q.size() > 1) chk("addr1", rd_q[1], a1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 32'hF000000F;
    mem[1] = 32'h00000001;
    mem[31] = 32'hA0000000;
    mem_rdata = '0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_base = '0;
    req_index = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_frag", int'(rsp_fragment), 0);

    send(0, -4, 8'hF0, 3, 1, 0, 0);
    send(24, 4, 8'h1F, 4, 2, 0, 1);
    send(1016, 4, 8'h0A, 3, 1, 31, 0);
    send(0, -16, 8'h00, 1, 0, 0, 0);
    send(32, 0, 8'h01, 3, 1, 1, 0);
    send(1023, 0, 8'h01, 3, 1, 31, 0);
    send(1023, 1, 8'h00, 1, 0, 0, 0);
    send(4, -5, 8'h1E, 3, 1, 0, 0);

    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(24, 4, 8'h1F, 4, 2, 0, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_frag", int'(rsp_fragment), 8'h1F);
      chk("bp_req_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_same", int'(req_ready), 0);
    @(negedge clk);
    chk("bp_ready_after", int'(req_ready), 1);

    @(posedge clk); #1;
    req_valid = 1'b1;
    req_base = 10'd24;
    req_index = 6'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midop_rd_en", int'(mem_rd_en), 1);
    chk("midop_addr", int'(mem_addr), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_rd_en", int'(mem_rd_en), 0);
    chk("midrst_req_ready", int'(req_ready), 1);
    send(0, -4, 8'hF0, 3, 1, 0, 0);

    repeat (3) @(posedge clk);
    chk("pending_rsp", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
